tim_arbiter: RTL and testbench

Two-port arbiter in front of the tightly-integrated memory (`tim`). It merges the core's instruction-fetch port and data port onto the single `tim` request port, and tags every forwarded request with `tim_instr`. It routes each one-cycle-later `tim_ready`/`tim_rdata` response back to the port that issued it. A one-entry pending buffer per port absorbs collisions, so neither requester ever has to hold or retry a request.

---
 rtl/tim_arbiter.sv | 145 ++++++++++++++
 tb/tb_tim_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tim_arbiter.sv
// tim_arbiter: merges the instruction-fetch and data ports onto the single
// tim request port. Each forwarded request is tagged with tim_instr, and each
// one-cycle-later response is routed back to the port that issued it.
// When both ports collide, the losing request is held in a one-entry pending
// buffer for its port, so neither requester has to retry.
// Optional build macro: TIM_ARB_RR_EN. When it is defined, a tie between two
// new requests alternates between the ports. When it is undefined, the data
// port wins every tie.
module tim_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        tim_valid,
    output logic        tim_instr,
    output logic [31:0] tim_addr,
    output logic [31:0] tim_wdata,
    output logic [3:0]  tim_wstrb,
    input  logic [31:0] tim_rdata,
    input  logic        tim_ready,
    output logic        arb_err
);

    logic        pend_i_v;
    logic [31:0] pend_i_addr;
    logic        pend_d_v;
    logic [31:0] pend_d_addr;
    logic [31:0] pend_d_wdata;
    logic [3:0]  pend_d_wstrb;
    logic        own_v;
    logic        own_i;
    logic        err_q;
    logic        cand_i;
    logic        cand_d;
    logic        gnt_v;
    logic        gnt_i;
    logic        tie_i;

`ifdef TIM_ARB_RR_EN
    logic        last_i;
    assign tie_i = ~last_i;
`else
    assign tie_i = 1'b0;
`endif

    // A port has a candidate when it holds a pending entry or offers a new
    // request. A new request that arrives while the entry is pending is a
    // protocol violation and is dropped; the pending entry stays the candidate.
    assign cand_i = pend_i_v | imem_valid;
    assign cand_d = pend_d_v | dmem_valid;
    assign gnt_v  = cand_i | cand_d;

    // Choose the winner: a lone candidate wins; otherwise a pending entry
    // beats a new request; otherwise the tie-break decides.
    always_comb begin
        gnt_i = 1'b0;
        if (cand_i && !cand_d)
            gnt_i = 1'b1;
        else if (cand_i && cand_d)
            gnt_i = (pend_i_v != pend_d_v) ? pend_i_v : tie_i;
    end

    // Forward the granted request combinationally. All outputs are held low
    // while reset is asserted.
    always_comb begin
        tim_valid = 1'b0;
        tim_instr = 1'b0;
        tim_addr  = 32'd0;
        tim_wdata = 32'd0;
        tim_wstrb = 4'd0;
        if (reset && gnt_v) begin
            tim_valid = 1'b1;
            tim_instr = gnt_i;
            if (gnt_i) begin
                tim_addr = pend_i_v ? pend_i_addr : imem_addr;
            end else begin
                tim_addr  = pend_d_v ? pend_d_addr  : dmem_addr;
                tim_wdata = pend_d_v ? pend_d_wdata : dmem_wdata;
                tim_wstrb = pend_d_v ? pend_d_wstrb : dmem_wstrb;
            end
        end
    end

    // Return each response to the port that owned last cycle's request.
    assign imem_ready = reset & tim_ready & own_v & own_i;
    assign dmem_ready = reset & tim_ready & own_v & ~own_i;
    assign imem_rdata = imem_ready ? tim_rdata : 32'd0;
    assign dmem_rdata = dmem_ready ? tim_rdata : 32'd0;
    assign arb_err    = err_q;

    // Update the ownership record, the pending entries and the sticky
    // error flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_i_v     <= 1'b0;
            pend_i_addr  <= 32'd0;
            pend_d_v     <= 1'b0;
            pend_d_addr  <= 32'd0;
            pend_d_wdata <= 32'd0;
            pend_d_wstrb <= 4'd0;
            own_v        <= 1'b0;
            own_i        <= 1'b0;
            err_q        <= 1'b0;
`ifdef TIM_ARB_RR_EN
            last_i       <= 1'b1;
`endif
        end else begin
            own_v <= gnt_v;
            own_i <= gnt_i;
`ifdef TIM_ARB_RR_EN
            if (gnt_v)
                last_i <= gnt_i;
`endif
            // Instruction entry: drained on its grant, filled by a losing new request.
            if (pend_i_v) begin
                if (gnt_i)
                    pend_i_v <= 1'b0;
            end else if (imem_valid && !gnt_i) begin
                pend_i_v    <= 1'b1;
                pend_i_addr <= imem_addr;
            end
            // Data entry: same rule. A grant to the data port is gnt_v with gnt_i=0.
            if (pend_d_v) begin
                if (!gnt_i)
                    pend_d_v <= 1'b0;
            end else if (dmem_valid && gnt_i) begin
                pend_d_v     <= 1'b1;
                pend_d_addr  <= dmem_addr;
                pend_d_wdata <= dmem_wdata;
                pend_d_wstrb <= dmem_wstrb;
            end
            if ((imem_valid && pend_i_v) || (dmem_valid && pend_d_v))
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tim_arbiter.sv
// tb_tim_arbiter: directed test-plan scenarios followed by randomized traffic.
// Every cycle is compared against an age-ordered queue model of the arbiter.
module tb_tim_arbiter;

    logic        clock;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        tim_valid;
    logic        tim_instr;
    logic [31:0] tim_addr;
    logic [31:0] tim_wdata;
    logic [3:0]  tim_wstrb;
    logic [31:0] tim_rdata;
    logic        tim_ready;
    logic        arb_err;

    tim_arbiter dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .tim_valid(tim_valid), .tim_instr(tim_instr),
        .tim_addr(tim_addr), .tim_wdata(tim_wdata), .tim_wstrb(tim_wstrb),
        .tim_rdata(tim_rdata), .tim_ready(tim_ready), .arb_err(arb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: each port keeps a queue of waiting requests stamped with
    // their arrival cycle. The oldest head is served first; equal ages go to the
    // configured tie-break.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          age;
    } req_t;

    req_t iq[$];
    req_t dq[$];
    int   own    = -1;   // -1 none, 0 data, 1 instruction
    bit   m_err  = 1'b0;
    bit   m_last = 1'b1;
    int   cyc    = 0;

    // One clock cycle: drive inputs just after the edge, let them settle,
    // then compare every output against the model.
    task automatic cyc_step(input bit rn, input bit iv, input logic [31:0] ia,
                            input bit dv, input logic [31:0] da, input logic [31:0] dw,
                            input logic [3:0] ds, input bit tr, input logic [31:0] trd);
        int win;
        bit nerr;
        bit eir;
        bit edr;
        req_t r;
        @(posedge clock);
        #1;
        reset = rn; imem_valid = iv; imem_addr = ia;
        dmem_valid = dv; dmem_addr = da; dmem_wdata = dw; dmem_wstrb = ds;
        tim_ready = tr; tim_rdata = trd;
        #2;
        chk("arb_err", 32'(arb_err), 32'(m_err));
        if (!rn) begin
            chk("rst_tim_valid", 32'(tim_valid), 32'd0);
            chk("rst_imem_ready", 32'(imem_ready), 32'd0);
            chk("rst_dmem_ready", 32'(dmem_ready), 32'd0);
            chk("rst_imem_rdata", imem_rdata, 32'd0);
            chk("rst_dmem_rdata", dmem_rdata, 32'd0);
            iq.delete(); dq.delete();
            own = -1; m_err = 1'b0; m_last = 1'b1;
        end else begin
            nerr = m_err;
            if (iv) begin
                if (iq.size() != 0) nerr = 1'b1;
                else begin r = '{ia, 32'd0, 4'd0, cyc}; iq.push_back(r); end
            end
            if (dv) begin
                if (dq.size() != 0) nerr = 1'b1;
                else begin r = '{da, dw, ds, cyc}; dq.push_back(r); end
            end
            win = -1;
            if (iq.size() != 0 && dq.size() != 0) begin
                if (iq[0].age < dq[0].age) win = 1;
                else if (dq[0].age < iq[0].age) win = 0;
                else begin
`ifdef TIM_ARB_RR_EN
                    win = m_last ? 0 : 1;
`else
                    win = 0;
`endif
                end
            end else if (iq.size() != 0) win = 1;
            else if (dq.size() != 0) win = 0;

            chk("tim_valid", 32'(tim_valid), 32'(win >= 0));
            if (win >= 0) begin
                r = (win == 1) ? iq.pop_front() : dq.pop_front();
                chk("tim_instr", 32'(tim_instr), 32'(win == 1));
                chk("tim_addr", tim_addr, r.addr);
                chk("tim_wdata", tim_wdata, r.wdata);
                chk("tim_wstrb", 32'(tim_wstrb), 32'(r.wstrb));
                m_last = (win == 1);
            end
            eir = tr && own == 1;
            edr = tr && own == 0;
            chk("imem_ready", 32'(imem_ready), 32'(eir));
            chk("dmem_ready", 32'(dmem_ready), 32'(edr));
            chk("imem_rdata", imem_rdata, eir ? trd : 32'd0);
            chk("dmem_rdata", dmem_rdata, edr ? trd : 32'd0);
            own = win;
            m_err = nerr;
        end
        cyc++;
    endtask

    task automatic idle(input bit tr);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, tr, 32'hA5A5_0000);
    endtask

    task automatic do_reset();
        cyc_step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
        cyc_step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    endtask

    bit          rn, iv, dv, tr;
    logic [31:0] ia, da, dw, trd;
    logic [3:0]  ds;

    initial begin
        reset = 1'b0; imem_valid = 1'b0; imem_addr = 32'd0;
        dmem_valid = 1'b0; dmem_addr = 32'd0; dmem_wdata = 32'd0; dmem_wstrb = 4'd0;
        tim_ready = 1'b0; tim_rdata = 32'd0;
        do_reset();
        chk("reset_arb_err", 32'(arb_err), 32'd0);
        chk("reset_tim_valid", 32'(tim_valid), 32'd0);

        // Single instruction fetch
        cyc_step(1'b1, 1'b1, 32'h10, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
        chk("t1_instr", 32'(tim_instr), 32'd1);
        chk("t1_wstrb", 32'(tim_wstrb), 32'd0);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'hDEAD_BEEF);
        chk("t1_iready", 32'(imem_ready), 32'd1);
        chk("t1_irdata", imem_rdata, 32'hDEAD_BEEF);
        chk("t1_dready", 32'(dmem_ready), 32'd0);

        // Simultaneous new requests right after reset: data wins in both builds
        do_reset();
        cyc_step(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0, 32'd0);
        chk("t2_first_data", 32'(tim_instr), 32'd0);
        chk("t2_wdata", tim_wdata, 32'h1234_5678);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h0000_1111);
        chk("t2_dready", 32'(dmem_ready), 32'd1);
        chk("t2_loser_instr", 32'(tim_instr), 32'd1);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h0000_2222);
        chk("t2_iready", 32'(imem_ready), 32'd1);
        // Second collision pair, checked against the model's tie-break rule
        cyc_step(1'b1, 1'b1, 32'h14, 1'b1, 32'h24, 32'h9, 4'h3, 1'b0, 32'd0);
        idle(1'b1);
        idle(1'b1);

        // Aging: the pending instruction beats a fresh data request
        do_reset();
        cyc_step(1'b1, 1'b1, 32'h30, 1'b1, 32'h40, 32'h5, 4'h1, 1'b0, 32'd0);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b1, 32'h44, 32'h6, 4'h2, 1'b1, 32'h0000_3333);
        chk("t4_pend_instr", 32'(tim_instr), 32'd1);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h0000_4444);
        chk("t4_buf_addr", tim_addr, 32'h44);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h0000_5555);
        chk("t4_dready_n3", 32'(dmem_ready), 32'd1);

        // Protocol error: a second fetch while the first is still pending
        do_reset();
        cyc_step(1'b1, 1'b1, 32'h50, 1'b1, 32'h60, 32'h7, 4'h4, 1'b0, 32'd0);
        cyc_step(1'b1, 1'b1, 32'h54, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h1);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h2);
        chk("t5_err_set", 32'(arb_err), 32'd1);
        idle(1'b1);
        chk("t5_no_2nd_iready", 32'(imem_ready), 32'd0);
        idle(1'b0);
        chk("t5_err_sticky", 32'(arb_err), 32'd1);
        do_reset();
        chk("t5_err_clear", 32'(arb_err), 32'd0);

        // Reset in the cycle after a grant
        cyc_step(1'b1, 1'b1, 32'h70, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
        cyc_step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'hBAD0_BAD0);
        chk("t6_no_iready", 32'(imem_ready), 32'd0);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b1, 32'h80, 32'h8, 4'h8, 1'b0, 32'd0);
        chk("t6_fresh_valid", 32'(tim_valid), 32'd1);
        cyc_step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'hCAFE_0001);
        chk("t6_fresh_dready", 32'(dmem_ready), 32'd1);

        // Randomized traffic with occasional violations, spurious responses and resets
        for (int n = 0; n < 3000; n++) begin
            rn  = ($urandom_range(0, 59) != 0);
            iv  = (iq.size() == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
            dv  = (dq.size() == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
            tr  = (own != -1) || ($urandom_range(0, 7) == 0);
            ia  = $urandom; da = $urandom; dw = $urandom; trd = $urandom;
            ds  = 4'($urandom_range(0, 15));
            cyc_step(rn, iv, ia, dv, da, dw, ds, tr, trd);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
